// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetches take absolute priority, game-logic
// writes are buffered in a small FIFO and drained in free (optionally blanked) cycles.
module vram_arbiter #(
    parameter int unsigned AW            = 7,
    parameter int unsigned DW            = 4,
    parameter int unsigned DEPTH         = 4,
    parameter bit          WR_BLANK_ONLY = 1'b1
) (
    input  logic                     pixel_clk,
    input  logic                     rst,
    input  logic                     blank,
    input  logic                     disp_req,
    input  logic [AW-1:0]            disp_addr,
    output logic                     disp_valid,
    output logic [DW-1:0]            disp_data,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DW-1:0]            wr_data,
    input  logic                     wr_flush,
    output logic                     wr_pending,
    output logic [$clog2(DEPTH):0]   wr_count,
    output logic                     mem_en,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic [DW-1:0]            mem_rdata
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_entry_t;

    state_e          state_q, state_d;

    wr_entry_t       fifo_q [DEPTH];
    wr_entry_t       head_c;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_c;
    logic            pop_c;
    logic            drain_c;

    logic            mem_en_q, mem_en_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

    logic            rd_wait_q;
    logic            disp_valid_q;
    logic [DW-1:0]   disp_data_q;

    // Write-side handshake; flush wins over both push and pop in its cycle.
    assign wr_ready = rst && (count_q < CW'(DEPTH));
    assign push_c   = wr_valid && wr_ready && !wr_flush;
    assign drain_c  = (count_q != '0) && !disp_req && (blank || !WR_BLANK_ONLY) && !wr_flush;
    assign pop_c    = drain_c;
    assign head_c   = fifo_q[rd_ptr_q];

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO storage carries no reset; occupancy alone qualifies its contents.
    always_ff @(posedge pixel_clk) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= '{addr: wr_addr, data: wr_data};
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Issue state register
    always_ff @(posedge pixel_clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next issue: display always wins, otherwise drain one buffered write.
    always_comb begin
        state_d = ST_IDLE;
        if (disp_req) begin
            state_d = ST_READ;
        end else if (drain_c) begin
            state_d = ST_WRITE;
        end
    end

    // VRAM port values for the upcoming issue; address/data hold when idle.
    always_comb begin
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_d)
            ST_READ: begin
                mem_en_d   = 1'b1;
                mem_addr_d = disp_addr;
            end
            ST_WRITE: begin
                mem_en_d    = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = head_c.addr;
                mem_wdata_d = head_c.data;
            end
            default: begin
                mem_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst) begin
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Read return: VRAM answers one cycle after issue, then one register stage.
    always_ff @(posedge pixel_clk) begin
        if (!rst) begin
            rd_wait_q    <= 1'b0;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            rd_wait_q    <= (state_q == ST_READ);
            disp_valid_q <= rd_wait_q;
            if (rd_wait_q) begin
                disp_data_q <= mem_rdata;
            end
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign wr_count   = count_q;
    assign wr_pending = (count_q != '0);

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural VRAM and scoreboard queues
// for read issue, read return and write drain order.
module tb_vram_arbiter;

    localparam int unsigned AW = 7;
    localparam int unsigned DW = 4;
    localparam int unsigned CW = 3;

    logic           pixel_clk = 1'b0;
    logic           rst;
    logic           blank;
    logic           disp_req;
    logic [AW-1:0]  disp_addr;
    logic           disp_valid;
    logic [DW-1:0]  disp_data;
    logic           wr_valid;
    logic           wr_ready;
    logic [AW-1:0]  wr_addr;
    logic [DW-1:0]  wr_data;
    logic           wr_flush;
    logic           wr_pending;
    logic [CW-1:0]  wr_count;
    logic           mem_en;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [DW-1:0]  mem_rdata;

    vram_arbiter #(.AW(AW), .DW(DW), .DEPTH(4), .WR_BLANK_ONLY(1'b1)) dut (
        .pixel_clk  (pixel_clk),
        .rst        (rst),
        .blank      (blank),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_flush   (wr_flush),
        .wr_pending (wr_pending),
        .wr_count   (wr_count),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 pixel_clk = ~pixel_clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned edge_cnt = 0;
    int          reads_seen = 0;
    int          writes_seen = 0;
    int          r0, w0;

    int unsigned          iss_stamp_q[$];
    logic [AW-1:0]        iss_addr_q[$];
    int unsigned          val_stamp_q[$];
    logic [DW-1:0]        val_data_q[$];
    logic [AW+DW-1:0]     wq[$];

    logic [DW-1:0] vram [128];
    bit            vram_init = 1'b0;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        if (a == 7'h2A) return 4'h5;
        return a[3:0] ^ {1'b0, a[6:4]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    always @(posedge pixel_clk) edge_cnt <= edge_cnt + 1;

    // Behavioural synchronous single-port VRAM
    always @(posedge pixel_clk) begin
        if (!vram_init) begin
            for (int i = 0; i < 128; i++) vram[i] <= init_val(AW'(i));
            vram_init <= 1'b1;
        end else if (mem_en === 1'b1) begin
            if (mem_we === 1'b1) vram[mem_addr] <= mem_wdata;
            else                 mem_rdata <= vram[mem_addr];
        end
    end

    // Scoreboard monitor, sampled mid-cycle
    always @(negedge pixel_clk) begin
        if (mem_en === 1'b1 && mem_we === 1'b0) begin
            reads_seen++;
            chk("read_expected", 32'(iss_addr_q.size() > 0), 1);
            if (iss_addr_q.size() > 0) begin
                chk("read_addr", 32'(mem_addr), 32'(iss_addr_q.pop_front()));
                chk("read_issue_cycle", edge_cnt, iss_stamp_q.pop_front());
            end
        end
        if (mem_en === 1'b1 && mem_we === 1'b1) begin
            writes_seen++;
            chk("write_expected", 32'(wq.size() > 0), 1);
            if (wq.size() > 0) chk("write_entry", 32'({mem_addr, mem_wdata}), 32'(wq.pop_front()));
        end
        if (disp_valid === 1'b1) begin
            chk("valid_expected", 32'(val_data_q.size() > 0), 1);
            if (val_data_q.size() > 0) begin
                chk("disp_data", 32'(disp_data), 32'(val_data_q.pop_front()));
                chk("disp_valid_cycle", edge_cnt, val_stamp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge pixel_clk);
        #2;
    endtask

    task automatic req_read(input logic [AW-1:0] a, input logic [DW-1:0] d);
        disp_req  = 1'b1;
        disp_addr = a;
        iss_addr_q.push_back(a);
        iss_stamp_q.push_back(edge_cnt + 1);
        val_data_q.push_back(d);
        val_stamp_q.push_back(edge_cnt + 3);
    endtask

    task automatic offer_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        if (wr_ready && !wr_flush) wq.push_back({a, d});
    endtask

    task automatic chk_reset_outputs(input string phase);
        chk({phase, "_mem_en"}, 32'(mem_en), 0);
        chk({phase, "_mem_we"}, 32'(mem_we), 0);
        chk({phase, "_mem_addr"}, 32'(mem_addr), 0);
        chk({phase, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({phase, "_disp_valid"}, 32'(disp_valid), 0);
        chk({phase, "_disp_data"}, 32'(disp_data), 0);
        chk({phase, "_wr_count"}, 32'(wr_count), 0);
        chk({phase, "_wr_pending"}, 32'(wr_pending), 0);
        chk({phase, "_wr_ready"}, 32'(wr_ready), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; blank = 1'b0; disp_req = 1'b0; disp_addr = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_flush = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("init");

        rst = 1'b1;
        tick();
        chk("ready_out_of_reset", 32'(wr_ready), 1);

        // Single fetch with exact latency
        req_read(7'h2A, 4'h5);
        tick();
        disp_req = 1'b0;
        chk("fetch_mem_en", 32'(mem_en), 1);
        chk("fetch_mem_we", 32'(mem_we), 0);
        chk("fetch_mem_addr", 32'(mem_addr), 32'h2A);
        tick();
        chk("fetch_valid_early", 32'(disp_valid), 0);
        tick();
        chk("fetch_valid", 32'(disp_valid), 1);
        chk("fetch_data", 32'(disp_data), 5);
        tick();
        chk("fetch_valid_drop", 32'(disp_valid), 0);

        // Back-to-back fetches
        for (int i = 0; i < 6; i++) begin
            req_read(AW'(8'h40 + i), init_val(AW'(8'h40 + i)));
            tick();
        end
        disp_req = 1'b0;
        repeat (4) tick();

        // Blank-gated write
        blank = 1'b0;
        offer_write(7'h10, 4'h3);
        tick();
        wr_valid = 1'b0;
        chk("gated_pending", 32'(wr_pending), 1);
        chk("gated_count", 32'(wr_count), 1);
        w0 = writes_seen;
        repeat (3) tick();
        chk("gated_no_write", writes_seen, w0);
        chk("gated_no_we", 32'(mem_we), 0);
        blank = 1'b1;
        tick();
        chk("gated_we", 32'(mem_we), 1);
        chk("gated_addr", 32'(mem_addr), 32'h10);
        chk("gated_wdata", 32'(mem_wdata), 3);
        chk("gated_count_zero", 32'(wr_count), 0);
        chk("gated_pending_zero", 32'(wr_pending), 0);
        tick();
        req_read(7'h10, 4'h3);
        tick();
        disp_req = 1'b0;
        repeat (4) tick();

        // Contention: display holds the port while writes wait
        r0 = reads_seen; w0 = writes_seen;
        req_read(7'h50, init_val(7'h50));
        offer_write(7'h20, 4'h7);
        tick();
        chk("cont_we_0", 32'(mem_we), 0);
        req_read(7'h51, init_val(7'h51));
        offer_write(7'h21, 4'h8);
        tick();
        wr_valid = 1'b0;
        chk("cont_we_1", 32'(mem_we), 0);
        for (int i = 0; i < 3; i++) begin
            req_read(AW'(8'h52 + i), init_val(AW'(8'h52 + i)));
            tick();
            chk("cont_we_held", 32'(mem_we), 0);
        end
        disp_req = 1'b0;
        chk("cont_count", 32'(wr_count), 2);
        tick();
        chk("cont_w1_we", 32'(mem_we), 1);
        chk("cont_w1", 32'({mem_addr, mem_wdata}), 32'({7'h20, 4'h7}));
        tick();
        chk("cont_w2_we", 32'(mem_we), 1);
        chk("cont_w2", 32'({mem_addr, mem_wdata}), 32'({7'h21, 4'h8}));
        tick();
        chk("cont_idle", 32'(mem_en), 0);
        chk("cont_reads", reads_seen - r0, 5);
        chk("cont_writes", writes_seen - w0, 2);
        repeat (3) tick();

        // Full buffer and flush
        blank = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer_write(AW'(8'h60 + i), DW'(i));
            tick();
        end
        chk("full_count", 32'(wr_count), 4);
        chk("full_ready", 32'(wr_ready), 0);
        w0 = writes_seen;
        offer_write(7'h64, 4'h9);
        tick();
        chk("full_fifth_rejected", 32'(wr_count), 4);
        wr_flush = 1'b1;
        wq.delete();
        tick();
        wr_flush = 1'b0;
        wr_valid = 1'b0;
        chk("flush_count", 32'(wr_count), 0);
        chk("flush_ready", 32'(wr_ready), 1);
        chk("flush_pending", 32'(wr_pending), 0);
        blank = 1'b1;
        repeat (3) tick();
        chk("flush_no_write", writes_seen, w0);

        // Pointer wrap with simultaneous push and pop
        blank = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offer_write(AW'(8'h30 + i), DW'(4'hA + i));
            tick();
        end
        blank = 1'b1;
        for (int i = 3; i < 6; i++) begin
            offer_write(AW'(8'h30 + i), DW'(4'hA + i));
            tick();
            chk("wrap_count_steady", 32'(wr_count), 3);
        end
        wr_valid = 1'b0;
        repeat (4) tick();
        chk("wrap_drained", 32'(wr_count), 0);
        req_read(7'h35, 4'hF);
        tick();
        disp_req = 1'b0;
        repeat (4) tick();

        // Reset mid-flight discards the read return and the buffered write
        blank = 1'b0;
        offer_write(7'h70, 4'h6);
        tick();
        wr_valid = 1'b0;
        w0 = writes_seen;
        req_read(7'h05, init_val(7'h05));
        tick();
        disp_req = 1'b0;
        rst = 1'b0;
        val_data_q.delete();
        val_stamp_q.delete();
        wq.delete();
        #1;
        chk("rst_ready_low", 32'(wr_ready), 0);
        tick();
        chk_reset_outputs("midrst");
        tick();
        tick();
        chk("midrst_no_valid", 32'(disp_valid), 0);
        chk("midrst_ready_held", 32'(wr_ready), 0);
        rst = 1'b1;
        blank = 1'b1;
        tick();
        chk("midrst_ready_back", 32'(wr_ready), 1);
        repeat (4) tick();
        chk("midrst_write_discarded", writes_seen, w0);

        // First request after reset is honoured
        req_read(7'h2A, 4'h5);
        tick();
        disp_req = 1'b0;
        repeat (6) tick();

        chk("end_issue_q_empty", iss_addr_q.size(), 0);
        chk("end_valid_q_empty", val_data_q.size(), 0);
        chk("end_write_q_empty", wq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
